// File: rtl/mux_channel_scanner.sv
// rtl/mux_channel_scanner.sv - scans the enabled channels of an external 4:1 mux and captures one bit per channel
module mux_channel_scanner #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       Y_in,
  output logic       S1,
  output logic       S0,
  output logic       busy,
  output logic [3:0] data_out,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Capture happens on the last cycle of a channel's dwell.
  localparam logic [3:0] LAST_CNT = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;

  logic [1:0] first_ch;
  logic [1:0] next_ch;
  logic       has_next;
  logic [3:0] cap_word;

  // Lowest enabled channel of the incoming mask, used when a scan is accepted.
  always_comb begin
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) first_ch = 2'(i);
    end
  end

  // Next enabled channel above the current one; disabled channels are skipped outright.
  always_comb begin
    has_next = 1'b0;
    next_ch  = ch_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        has_next = 1'b1;
        next_ch  = 2'(i);
      end
    end
  end

  // Shadow word with the current channel's sample merged in.
  always_comb begin
    cap_word       = shadow_q;
    cap_word[ch_q] = Y_in;
  end

  // Next-state logic: accept, dwell/capture/advance, then hold the word until consumed.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (start && (mask != 4'd0)) begin
          state_d  = SCAN;
          mask_d   = mask;
          ch_d     = first_ch;
          cnt_d    = 4'd0;
          shadow_d = 4'd0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST_CNT) begin
          shadow_d = cap_word;
          if (has_next) begin
            ch_d  = next_ch;
            cnt_d = 4'd0;
          end else begin
            data_d  = cap_word;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = 2'd0;
        cnt_d   = 4'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any scan and discards the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= 4'd0;
      mask_q   <= 4'd0;
      shadow_q <= 4'd0;
      data_q   <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  // The select lines come straight from the channel register, which is zero whenever idle.
  assign S1       = ch_q[1];
  assign S0       = ch_q[0];
  assign busy     = (state_q != IDLE);
  assign valid    = valid_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// tb/tb_mux_channel_scanner.sv - scoreboard bench for mux_channel_scanner at DWELL=2 and DWELL=1
module tb_mux_channel_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_s  [2];
  logic [3:0] mask_s   [2];
  logic       ready_s  [2];
  logic [3:0] mux_in   [2];
  logic       y_s      [2];
  logic       s1_s     [2];
  logic       s0_s     [2];
  logic       busy_s   [2];
  logic [3:0] data_s   [2];
  logic       valid_s  [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  assign y_s[0] = mux_in[0][{s1_s[0], s0_s[0]}];
  assign y_s[1] = mux_in[1][{s1_s[1], s0_s[1]}];

  mux_channel_scanner #(.DWELL(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mask(mask_s[0]), .Y_in(y_s[0]),
    .S1(s1_s[0]), .S0(s0_s[0]), .busy(busy_s[0]), .data_out(data_s[0]),
    .valid(valid_s[0]), .ready(ready_s[0])
  );

  mux_channel_scanner #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mask(mask_s[1]), .Y_in(y_s[1]),
    .S1(s1_s[1]), .S0(s0_s[1]), .busy(busy_s[1]), .data_out(data_s[1]),
    .valid(valid_s[1]), .ready(ready_s[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full scan on unit u; checks the select sequence, latency and word, holds DONE for 'hold' cycles.
  task automatic do_scan(input int u, input logic [3:0] m, input logic [3:0] din, input int hold);
    int dw;
    int seq[$];
    int k;
    logic [3:0] w;
    dw = (u == 1) ? 1 : 2;
    for (int c = 0; c < 4; c++)
      if (m[c]) for (int d = 0; d < dw; d++) seq.push_back(c);
    @(negedge clk);
    mux_in[u]  = din;
    mask_s[u]  = m;
    start_s[u] = 1'b1;
    exp_q.push_back(din & m);
    @(negedge clk);
    mask_s[u] = ~m;
    k = 0;
    while (!valid_s[u] && k < seq.size() + 4) begin
      if (k < seq.size()) begin
        check_eq($sformatf("u%0d_sel_%0d", u, k), {30'd0, s1_s[u], s0_s[u]}, seq[k]);
        check_eq($sformatf("u%0d_busy_scan", u), busy_s[u], 1);
      end
      start_s[u] = k[0];
      @(negedge clk);
      k++;
    end
    start_s[u] = 1'b0;
    check_eq($sformatf("u%0d_latency", u), k, seq.size());
    check_eq($sformatf("u%0d_valid", u), valid_s[u], 1);
    check_eq($sformatf("u%0d_sel_done", u), {30'd0, s1_s[u], s0_s[u]}, seq[seq.size()-1]);
    w = exp_q.pop_front();
    check_eq($sformatf("u%0d_data", u), data_s[u], w);
    for (int h = 0; h < hold; h++) begin
      ready_s[u] = 1'b0;
      start_s[u] = 1'b1;
      @(negedge clk);
      check_eq("hold_data", data_s[u], w);
      check_eq("hold_busy", busy_s[u], 1);
      check_eq("hold_valid", valid_s[u], 1);
    end
    ready_s[u] = 1'b1;
    start_s[u] = (hold > 0);
    @(negedge clk);
    ready_s[u] = 1'b0;
    start_s[u] = 1'b0;
    check_eq($sformatf("u%0d_idle_busy", u), busy_s[u], 0);
    check_eq($sformatf("u%0d_idle_valid", u), valid_s[u], 0);
    check_eq($sformatf("u%0d_idle_sel", u), {s1_s[u], s0_s[u]}, 0);
    check_eq($sformatf("u%0d_idle_data", u), data_s[u], w);
  endtask

  initial begin
    logic [3:0] prev_data;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      mask_s[u]  = 4'd0;
      ready_s[u] = 1'b0;
      mux_in[u]  = 4'd0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq("rst_busy", busy_s[u], 0);
      check_eq("rst_valid", valid_s[u], 0);
      check_eq("rst_sel", {s1_s[u], s0_s[u]}, 0);
      check_eq("rst_data", data_s[u], 0);
    end
    rst_n = 1'b1;

    do_scan(0, 4'b1111, 4'b1101, 0);
    do_scan(0, 4'b1010, 4'b1111, 0);
    do_scan(0, 4'b1111, 4'b1011, 5);

    @(negedge clk);
    prev_data  = data_s[0];
    mask_s[0]  = 4'b0000;
    start_s[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("m0_busy", busy_s[0], 0);
      check_eq("m0_valid", valid_s[0], 0);
      check_eq("m0_sel", {s1_s[0], s0_s[0]}, 0);
      check_eq("m0_data", data_s[0], prev_data);
    end
    start_s[0] = 1'b0;

    mux_in[0]  = 4'b0101;
    mask_s[0]  = 4'b1111;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_sel", {s1_s[0], s0_s[0]}, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy_s[0], 0);
    check_eq("arst_valid", valid_s[0], 0);
    check_eq("arst_sel", {s1_s[0], s0_s[0]}, 0);
    check_eq("arst_data", data_s[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_scan(0, 4'b1111, 4'b0110, 0);

    do_scan(1, 4'b1111, 4'b1010, 0);
    do_scan(1, 4'b0110, 4'b1111, 2);

    for (int i = 0; i < 4; i++) begin
      do_scan(0, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), i % 2);
      do_scan(1, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 0);
    end

    check_eq("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mux_channel_scanner.md
MUX_CHANNEL_SCANNER -- requirements
Module: mux_channel_scanner

Interface
REQ-001 Parameter DWELL, default 2, meaning clock cycles each channel stays selected before its sample is taken; the legal range is 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  scan request, sampled only in IDLE.
REQ-005 mask  input  4  channel enables, bit i = channel i; latched on accepted start.
REQ-006 Y_in  input  1  output of the downstream 4:1 mux being scanned.
REQ-007 S1  output  1  mux select MSB, registered.
REQ-008 S0  output  1  mux select LSB, registered.
REQ-009 busy  output  1  high in SCAN and DONE states.
REQ-010 data_out  output  4  captured word, bit i = sample of channel i.
REQ-011 valid  output  1  data_out holds a completed scan.
REQ-012 ready  input  1  consumer accepts data_out when valid=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-014 IDLE: S1,S0=00, busy=0, valid=0; data_out SHALL hold its last value.
REQ-015 In IDLE, start=1 with mask!=0 SHALL latch mask, set ch=lowest enabled channel and dwell count cnt=0, and enter SCAN on the same edge.
REQ-016 In IDLE, start=1 with mask=0 SHALL be ignored: the FSM stays in IDLE and no outputs change.
REQ-017 start SHALL be ignored whenever busy=1, and mask changes after acceptance SHALL have no effect on the scan in progress.
REQ-018 SCAN: {S1,S0} SHALL equal ch for the entire dwell of that channel, and cnt SHALL increment every cycle.
REQ-019 At the edge where cnt==DWELL-1, Y_in SHALL be captured into shadow bit ch.
REQ-020 At that capture edge, if a higher enabled channel exists, ch SHALL advance to the next enabled channel in ascending order and cnt SHALL reset to 0; disabled channels SHALL consume no cycles.
REQ-021 At the capture edge of the last enabled channel, the block SHALL load data_out from the shadow including the just-captured bit, set valid=1 and enter DONE.
REQ-022 Bits of disabled channels SHALL read 0 in data_out, and the shadow SHALL be cleared on every accepted start.
REQ-023 Latency: valid SHALL rise N*DWELL edges after the edge that accepted start, where N is the popcount of the latched mask (for example N=4, DWELL=2 gives 8 edges).
REQ-024 DONE: {S1,S0} SHALL hold the last channel, and valid and data_out SHALL stay stable until ready=1.
REQ-025 An edge with valid=1 and ready=1 SHALL clear valid and return the FSM to IDLE, and a start on that same edge SHALL be ignored.
REQ-026 ready SHALL have no effect while valid=0.
REQ-027 The count cnt SHALL be 4 bits wide and SHALL never exceed DWELL-1, so no wrap-around occurs.

Reset
REQ-028 rst_n=0 SHALL immediately force, without waiting for clk: state=IDLE, S1,S0=00, busy=0, valid=0, data_out=0000, cnt=0, ch=0, and the latched mask and shadow cleared.
REQ-029 Reset asserted mid-SCAN or in DONE SHALL abort the scan and discard any partial word.
REQ-030 After rst_n deasserts, the first rising edge SHALL behave as in IDLE.

Verification
REQ-031 The bench SHALL cover: DWELL=2, mask=1111, mux inputs I0..I3=1,0,1,1 -> select sequence 00,00,01,01,10,10,11,11, then valid=1 with data_out=1101, 8 edges after start.
REQ-032 The bench SHALL cover: mask=1010, I1=1, I3=1 -> only selects 01 and 11 are driven, for 2 cycles each, then data_out=1010 after 4 edges.
REQ-033 The bench SHALL cover: ready held 0 for 5 cycles in DONE, then pulsed to 1 -> data_out stable, busy=1 throughout, and start pulses are ignored; IDLE is entered after the ready edge.
REQ-034 The bench SHALL cover: start with mask=0000 -> busy, valid, S1,S0 and data_out all unchanged.
REQ-035 The bench SHALL cover: rst_n pulled low mid-edge during the 3rd channel -> outputs cleared asynchronously, and a new start after reset produces a correct full 4-channel word.
REQ-036 The bench SHALL cover: DWELL=1, mask=1111 -> select changes every cycle and valid rises 4 edges after start.
